// File: rtl/vj_pkg.sv
// Shared types and constants for the face-detection front end.
package vj_pkg;

  localparam int unsigned PIXEL_BITS_DEF = 8;
  localparam int unsigned COUNT_W        = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/frame_loader_raster_counter.sv
// Raster-order row/column position tracker for the fill buffer.
module raster_counter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned HEIGHT = 3,
  localparam int unsigned RW = $clog2(HEIGHT),
  localparam int unsigned CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  input  logic          restart,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  // Restart points at (0,1): the SOF pixel itself occupies (0,0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (restart) begin
      row <= '0;
      col <= CW'(1);
    end else if (advance) begin
      if (col == CW'(WIDTH - 1)) begin
        col <= '0;
        row <= (row == RW'(HEIGHT - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Final raster position of the frame.
  always_comb begin
    last = (row == RW'(HEIGHT - 1)) && (col == CW'(WIDTH - 1));
  end

endmodule

// File: rtl/frame_loader.sv
// Double-buffered frame capture: fills a raster buffer and commits it to a held image.
`ifndef LAPTOP_WIDTH
`define LAPTOP_WIDTH 32
`endif
`ifndef LAPTOP_HEIGHT
`define LAPTOP_HEIGHT 24
`endif

module frame_loader
  import vj_pkg::*;
#(
  parameter int unsigned WIDTH      = `LAPTOP_WIDTH,
  parameter int unsigned HEIGHT     = `LAPTOP_HEIGHT,
  parameter int unsigned PIXEL_BITS = PIXEL_BITS_DEF
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [PIXEL_BITS-1:0]               pixel_in,
  input  logic                                pixel_valid,
  input  logic                                pixel_sof,
  output logic                                pixel_ready,
  output logic [HEIGHT-1:0][WIDTH-1:0][31:0]  frame_img,
  output logic                                frame_valid,
  input  logic                                frame_ack,
  output logic                                frame_done,
  output logic                                frame_error,
  output logic [COUNT_W-1:0]                  frame_count
);

  localparam int unsigned RW = $clog2(HEIGHT);
  localparam int unsigned CW = $clog2(WIDTH);

  state_t          state, state_next;
  logic            accept, restart, advance, commit, direct, wr_en, error_set;
  logic [RW-1:0]   row, wr_row;
  logic [CW-1:0]   col, wr_col;
  logic            last;
  logic [PIXEL_BITS-1:0] fill [HEIGHT][WIDTH];

  raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance),
    .restart (restart),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  // Back-pressure only while a completed frame waits for the consumer.
  always_comb begin
    pixel_ready = (state != HOLD);
    accept      = pixel_valid && pixel_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state, fill-buffer write control and commit decision.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    advance    = 1'b0;
    commit     = 1'b0;
    direct     = 1'b0;
    wr_en      = 1'b0;
    error_set  = 1'b0;
    wr_row     = row;
    wr_col     = col;
    case (state)
      IDLE: begin
        if (accept && pixel_sof) begin
          restart    = 1'b1;
          wr_en      = 1'b1;
          wr_row     = '0;
          wr_col     = '0;
          state_next = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (pixel_sof) begin
            restart   = 1'b1;
            error_set = 1'b1;
            wr_row    = '0;
            wr_col    = '0;
          end else begin
            advance = 1'b1;
            if (last) begin
              if (!frame_valid || frame_ack) begin
                commit     = 1'b1;
                direct     = 1'b1;
                state_next = IDLE;
              end else begin
                state_next = HOLD;
              end
            end
          end
        end
      end
      HOLD: begin
        if (frame_ack) begin
          commit     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Fill buffer storage; aborted frames are simply overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) fill[wr_row][wr_col] <= pixel_in;
  end

  // Committed image and status outputs; a direct commit bypasses the buffer for the last pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_img   <= '0;
      frame_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done  <= commit;
      frame_error <= error_set;
      if (commit) begin
        for (int unsigned r = 0; r < HEIGHT; r++) begin
          for (int unsigned c = 0; c < WIDTH; c++) begin
            if (direct && r == HEIGHT - 1 && c == WIDTH - 1)
              frame_img[r][c] <= 32'(pixel_in);
            else
              frame_img[r][c] <= 32'(fill[r][c]);
          end
        end
        frame_valid <= 1'b1;
        frame_count <= frame_count + 1'b1;
      end else if (frame_ack && frame_valid) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
